// File: rtl/mem_pkg.sv
// Shared types and constants for the line memory responder and its storage array.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_BUSY  = 2'd1,
        MEM_GRANT = 2'd2
    } mem_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op_t;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned LATENCY_MAX = 1023;
    localparam int unsigned LAT_CNT_W   = $clog2(LATENCY_MAX + 1);

    function automatic int unsigned line_size(input int unsigned line_addr_len);
        return 32'd1 << line_addr_len;
    endfunction

endpackage

// File: rtl/line_store.sv
// Line-wide single-port storage: synchronous write, registered read that holds between reads.
module line_store
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_LEN = 9,
    parameter int unsigned LINE_W   = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we_i,
    input  logic                re_i,
    input  logic [ADDR_LEN-1:0] addr_i,
    input  logic [LINE_W-1:0]   wdata_i,
    output logic [LINE_W-1:0]   rdata_o
);

    logic [LINE_W-1:0] mem_q [2**ADDR_LEN];
    logic [LINE_W-1:0] rdata_q;

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register only moves on a read, so it holds the last line read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Line-granular backing memory: accepts one line read/write, pulses gnt_o LATENCY cycles later.
// Optional macro MEM_STATS_EN adds per-op completion counters rd_cnt_o / wr_cnt_o.
module line_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned ADDR_LEN      = 9,
    parameter int unsigned LATENCY       = 50
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [ADDR_LEN-1:0]                        addr_i,
    input  logic                                       rd_req_i,
    input  logic                                       wr_req_i,
    input  logic [line_size(LINE_ADDR_LEN)*WORD_W-1:0] wr_line_i,
    output logic [line_size(LINE_ADDR_LEN)*WORD_W-1:0] rd_line_o,
    output logic                                       gnt_o
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]                                rd_cnt_o,
    output logic [31:0]                                wr_cnt_o
`endif
);

    localparam int unsigned          LINE_W   = line_size(LINE_ADDR_LEN) * WORD_W;
    localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(LATENCY - 32'd1);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(32'd1);

    mem_state_t            state_q, state_d;
    mem_op_t               op_q, op_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_LEN-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]     wline_q, wline_d;
    logic                  gnt_q, gnt_d;

    logic                  req_s;
    logic                  commit_s;
    logic                  st_we_s;
    logic                  st_re_s;
    logic [ADDR_LEN-1:0]   st_addr_s;
    logic [LINE_W-1:0]     st_wdata_s;

    assign req_s = rd_req_i | wr_req_i;

    // State, latency counter, request latches and the registered grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
            op_q    <= OP_RD;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, abort if the request vanishes.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        case (state_q)
            MEM_IDLE: begin
                if (req_s) begin
                    // A simultaneous read is dropped in favour of the write.
                    op_d    = wr_req_i ? OP_WR : OP_RD;
                    addr_d  = addr_i;
                    wline_d = wr_line_i;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 32'd1) ? MEM_GRANT : MEM_BUSY;
                end else begin
                    state_d = MEM_IDLE;
                end
            end
            MEM_BUSY: begin
                if (!req_s) begin
                    state_d = MEM_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = MEM_GRANT;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            MEM_GRANT: begin
                state_d = MEM_IDLE;
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: storage access happens on the edge that enters GRANT, using next-state latches.
    always_comb begin
        gnt_d      = 1'b0;
        commit_s   = 1'b0;
        st_we_s    = 1'b0;
        st_re_s    = 1'b0;
        st_addr_s  = addr_d;
        st_wdata_s = wline_d;
        if ((state_d == MEM_GRANT) && (state_q != MEM_GRANT)) begin
            gnt_d    = 1'b1;
            commit_s = 1'b1;
        end else begin
            gnt_d    = 1'b0;
            commit_s = 1'b0;
        end
        st_we_s = commit_s && (op_d == OP_WR);
        st_re_s = commit_s && (op_d == OP_RD);
    end

    line_store #(
        .ADDR_LEN (ADDR_LEN),
        .LINE_W   (LINE_W)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (st_we_s),
        .re_i    (st_re_s),
        .addr_i  (st_addr_s),
        .wdata_i (st_wdata_s),
        .rdata_o (rd_line_o)
    );

    assign gnt_o = gnt_q;

`ifdef MEM_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    // Completion counters bump on the same edge that raises the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else begin
            if (st_re_s) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (st_we_s) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_line_mem_responder;

    localparam int LW = 256;

    typedef struct {
        bit             is_rd;
        logic [LW-1:0]  line;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           rd_req4, wr_req4, rd_req1, wr_req1;
    logic [8:0]     addr4, addr1;
    logic [LW-1:0]  wr_line4, wr_line1, rd_line4, rd_line1;
    logic           gnt4, gnt1;
`ifdef MEM_STATS_EN
    logic [31:0]    rd_cnt4, wr_cnt4, rd_cnt1, wr_cnt1;
`endif

    int             n_checks = 0;
    int             n_fail   = 0;
    int             cyc      = 0;
    exp_t           sb4[$];
    exp_t           sb1[$];
    exp_t           mon_e4, mon_e1;
    logic [LW-1:0]  model4 [512];
    logic [LW-1:0]  model1 [512];
    logic [LW-1:0]  last_rd4, last_rd1;
    logic [LW-1:0]  seq_line, a5_line, bad_line, t6_line;
    int             g_a, g_b;

    line_mem_responder #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .LATENCY(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_i    (addr4),
        .rd_req_i  (rd_req4),
        .wr_req_i  (wr_req4),
        .wr_line_i (wr_line4),
        .rd_line_o (rd_line4),
        .gnt_o     (gnt4)
`ifdef MEM_STATS_EN
        , .rd_cnt_o(rd_cnt4), .wr_cnt_o(wr_cnt4)
`endif
    );

    line_mem_responder #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .LATENCY(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_i    (addr1),
        .rd_req_i  (rd_req1),
        .wr_req_i  (wr_req1),
        .wr_line_i (wr_line1),
        .rd_line_o (rd_line1),
        .gnt_o     (gnt1)
`ifdef MEM_STATS_EN
        , .rd_cnt_o(rd_cnt1), .wr_cnt_o(wr_cnt1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumers: every grant must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && gnt4) begin
            if (sb4.size() == 0) begin
                check_eq("gnt4_spurious", 256'd1, 256'd0);
            end else begin
                mon_e4 = sb4.pop_front();
                if (mon_e4.is_rd) last_rd4 = mon_e4.line;
                check_eq(mon_e4.is_rd ? "rd4_line" : "wr4_rd_line_held", rd_line4, last_rd4);
            end
        end
        if (rst_n && gnt1) begin
            if (sb1.size() == 0) begin
                check_eq("gnt1_spurious", 256'd1, 256'd0);
            end else begin
                mon_e1 = sb1.pop_front();
                if (mon_e1.is_rd) last_rd1 = mon_e1.line;
                check_eq(mon_e1.is_rd ? "rd1_line" : "wr1_rd_line_held", rd_line1, last_rd1);
            end
        end
    end

    task automatic drive(input int sel, input bit rd, input bit wr, input logic [8:0] a, input logic [LW-1:0] l);
        if (sel == 1) begin
            rd_req1 = rd; wr_req1 = wr; addr1 = a; wr_line1 = l;
        end else begin
            rd_req4 = rd; wr_req4 = wr; addr4 = a; wr_line4 = l;
        end
    endtask

    // One request; drop_after>0 withdraws it in that cycle and expects no grant.
    task automatic line_req(input int sel, input bit rd, input bit wr, input logic [8:0] a,
                            input logic [LW-1:0] l, input int drop_after, output int gnt_cyc);
        int   lat;
        int   first;
        int   seen;
        bit   g;
        exp_t e;
        lat     = (sel == 1) ? 1 : 4;
        first   = -1;
        seen    = 0;
        gnt_cyc = -1;
        @(negedge clk);
        drive(sel, rd, wr, a, l);
        if (drop_after == 0) begin
            e.is_rd = !wr;
            if (sel == 1) begin
                e.line = wr ? l : model1[a];
                if (wr) model1[a] = l;
                sb1.push_back(e);
            end else begin
                e.line = wr ? l : model4[a];
                if (wr) model4[a] = l;
                sb4.push_back(e);
            end
        end
        @(posedge clk);
        for (int k = 1; k <= lat + 4; k++) begin
            @(negedge clk);
            g = (sel == 1) ? gnt1 : gnt4;
            if (g) begin
                seen++;
                if (first < 0) begin
                    first   = k;
                    gnt_cyc = cyc;
                end
                drive(sel, 1'b0, 1'b0, a, l);
                if (drop_after == 0) break;
            end
            if (drop_after != 0 && k == drop_after) drive(sel, 1'b0, 1'b0, a, l);
        end
        drive(sel, 1'b0, 1'b0, a, l);
        if (drop_after == 0) check_eq("gnt_latency", 256'(first), 256'(lat));
        else check_eq("abort_no_gnt", 256'(seen), 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            seq_line[32*i +: 32] = 32'(i);
            t6_line[32*i +: 32]  = 32'h1000_0000 + 32'(i);
        end
        a5_line  = {8{32'hA5A5_A5A5}};
        bad_line = {8{32'hDEAD_BEEF}};
        last_rd4 = '0;
        last_rd1 = '0;
        rst_n    = 1'b0;
        drive(4, 1'b0, 1'b0, 9'h000, '0);
        drive(1, 1'b0, 1'b0, 9'h000, '0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_gnt4", 256'(gnt4), 256'd0);
        check_eq("reset_rd_line4", rd_line4, 256'd0);
        check_eq("reset_gnt1", 256'(gnt1), 256'd0);
        check_eq("reset_rd_line1", rd_line1, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back, rd_line must hold while idle.
        line_req(4, 1'b0, 1'b1, 9'h005, seq_line, 0, g_a);
        line_req(4, 1'b1, 1'b0, 9'h005, '0, 0, g_a);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("rd_line_idle_hold", rd_line4, seq_line);
        end

        // Read and write together: write wins.
        line_req(4, 1'b1, 1'b1, 9'h010, a5_line, 0, g_a);
        line_req(4, 1'b1, 1'b0, 9'h010, '0, 0, g_a);

        // Aborted write leaves old data.
        line_req(4, 1'b0, 1'b1, 9'h005, bad_line, 2, g_a);
        line_req(4, 1'b1, 1'b0, 9'h005, '0, 0, g_a);

        // Reset in the middle of a read.
        @(negedge clk);
        drive(4, 1'b1, 1'b0, 9'h010, '0);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midbusy_rst_gnt", 256'(gnt4), 256'd0);
        check_eq("midbusy_rst_rd_line", rd_line4, 256'd0);
        drive(4, 1'b0, 1'b0, 9'h010, '0);
        last_rd4 = '0;
        last_rd1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        line_req(4, 1'b1, 1'b0, 9'h005, '0, 0, g_a);

        // LATENCY=1 back-to-back write then read.
        line_req(1, 1'b0, 1'b1, 9'h033, t6_line, 0, g_a);
        line_req(1, 1'b1, 1'b0, 9'h033, '0, 0, g_b);
        check_eq("b2b_gnt_gap", 256'(g_b - g_a), 256'd2);

        repeat (3) @(negedge clk);
        check_eq("sb4_drained", 256'(sb4.size()), 256'd0);
        check_eq("sb1_drained", 256'(sb1.size()), 256'd0);
`ifdef MEM_STATS_EN
        check_eq("wr_cnt1", 256'(wr_cnt1), 256'd1);
        check_eq("rd_cnt1", 256'(rd_cnt1), 256'd1);
        check_eq("wr_cnt4", 256'(wr_cnt4), 256'd0);
        check_eq("rd_cnt4", 256'(rd_cnt4), 256'd1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
